// File: rtl/serial_bit_source.sv
// Parallel-to-serial source: WIDTH-bit words in over valid/ready, one bit per clock out, LSB first.
// Define SERIAL_BIT_SOURCE_PARITY_EN to append an even-parity bit after every word.
module serial_bit_source #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out,
    output logic             out_valid,
    output logic             done,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

`ifdef SERIAL_BIT_SOURCE_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

    // Handshake: a word transfers on a rising edge where in_valid && in_ready.
    // in_ready depends only on registered state, never on in_valid.
    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_bit;
    logic             accept;
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
    logic             par_q, par_d;
`endif

    assign dbg_state = state_q;
    assign last_bit  = (state_q == SHIFT) && (cnt_q == LAST_CNT);

    always_comb begin
        out       = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        case (state_q)
            SHIFT: begin
                out       = sr_q[0];
                out_valid = 1'b1;
`ifndef SERIAL_BIT_SOURCE_PARITY_EN
                done      = last_bit;
`endif
            end
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
            PARITY: begin
                out       = par_q;
                out_valid = 1'b1;
                done      = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign in_ready = (state_q == IDLE) || done;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q == SHIFT) begin
            sr_d  = sr_q >> 1;
            cnt_d = cnt_q + CNT_W'(1);
            if (last_bit) begin
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
                state_d = PARITY;
`else
                state_d = IDLE;
`endif
            end
        end
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
        if (state_q == PARITY) begin
            state_d = IDLE;
        end
`endif
        // A word accepted in the done cycle overrides the return to IDLE: no gap.
        if (accept) begin
            state_d = SHIFT;
            sr_d    = in_data;
            cnt_d   = '0;
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
            par_d   = ^in_data;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_serial_bit_source.sv
// Bench for serial_bit_source (WIDTH = 8): directed words, cycle-stamped expected bits in a queue.
module tb_serial_bit_source;

    localparam int W = 8;
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int WORD_LEN = W + (PAR ? 1 : 0);
    localparam int EW = 34;   // {cycle[31:0], done, bit}

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out;
    logic         out_valid;
    logic         done;
    logic [1:0]   dbg_state;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    logic [EW-1:0] exp_q[$];

    serial_bit_source #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out       (out),
        .out_valid (out_valid),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // clock / cycle counter / watchdog
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [EW-1:0] mk(input int c, input logic d, input logic b);
        return {32'(c), d, b};
    endfunction

    // monitor: every presented bit must match the queue head, including its cycle stamp
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_bit: got out=%b done=%b expected no output (cycle %0d)",
                             out, done, cyc);
                end else begin
                    logic [EW-1:0] e;
                    logic [EW-1:0] a;
                    e = exp_q.pop_front();
                    a = {32'(cyc), done, out};
                    if (a !== e) begin
                        n_fail++;
                        $display("FAIL stream: got cycle=%0d done=%b out=%b expected cycle=%0d done=%b out=%b",
                                 cyc, done, out, e[33:2], e[1], e[0]);
                    end
                end
            end else begin
                n_checks++;
                if (out !== 1'b0 || done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL idle_outputs: got out=%b done=%b expected 0 0 (cycle %0d)", out, done, cyc);
                end
            end
        end
    end

    // driver: called at a negedge; returns at the negedge after the accepting edge
    task automatic send(input logic [W-1:0] w, input logic par, input bit hold, output int acc_cyc);
        int waited;
        waited = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (in_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (in_ready !== 1'b1) begin
            check("accept_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            acc_cyc  = -1;
            return;
        end
        acc_cyc = cyc;
        for (int k = 0; k < W; k++)
            exp_q.push_back(mk(cyc + 1 + k, (!PAR && k == W - 1), w[k]));
        if (PAR)
            exp_q.push_back(mk(cyc + 1 + W, 1'b1, par));
        @(posedge clk);
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
    endtask

    initial begin
        int a1;
        int a2;

        // reset held with in_valid high: nothing may be accepted
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        repeat (3) begin
            @(negedge clk);
            check("rst_out", 64'(out), 64'd0);
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_done", 64'(done), 64'd0);
            check("rst_in_ready", 64'(in_ready), 64'd1);
            check("rst_state", 64'(dbg_state), 64'd0);
        end
        in_valid = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
        check("post_rst_idle", 64'(out_valid), 64'd0);

        // single word 8'hA5: in_ready low until the final bit
        send(8'hA5, 1'b0, 1'b0, a1);
        for (int k = 0; k < WORD_LEN; k++) begin
            check("busy_in_ready", 64'(in_ready), 64'(k == WORD_LEN - 1));
            @(negedge clk);
        end
        check("a5_back_idle_valid", 64'(out_valid), 64'd0);
        check("a5_back_idle_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        // back-to-back 8'hFF then 8'h01 with in_valid held high
        send(8'hFF, 1'b0, 1'b1, a1);
        send(8'h01, 1'b1, 1'b0, a2);
        check("b2b_accept_gap", 64'(a2 - a1), 64'(WORD_LEN));
        repeat (WORD_LEN + 2) @(negedge clk);

        // parity vectors 8'h07 (parity 1) and 8'h03 (parity 0)
        send(8'h07, 1'b1, 1'b0, a1);
        repeat (WORD_LEN + 2) @(negedge clk);
        send(8'h03, 1'b0, 1'b0, a1);
        repeat (WORD_LEN + 2) @(negedge clk);

        // reset mid-word: outputs must drop without a clock edge
        send(8'hF0, 1'b0, 1'b0, a1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out", 64'(out), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(8'h0F, 1'b0, 1'b0, a1);
        repeat (WORD_LEN + 2) @(negedge clk);

        // in_data changes while busy are ignored; 8'hAA accepted only in the done cycle
        send(8'h55, 1'b0, 1'b1, a1);
        send(8'hAA, 1'b0, 1'b0, a2);
        check("busy_accept_cycle", 64'(a2 - a1), 64'(WORD_LEN));
        repeat (WORD_LEN + 3) @(negedge clk);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
